// File: rtl/vid_res_pkg.sv
// Shared types and helpers for the video resolution detector.
package vid_res_pkg;

  typedef enum logic [1:0] {StSearch, StLocking, StLocked} state_e;

  localparam int unsigned CntW = 13;

  // Increments val but never past the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/vid_line_counter.sv
// Per-frame line/pixel measurement; evaluates the closing frame on each vsync rise.
module vid_line_counter
  import vid_res_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_datavalid,
  input  logic             vid_vsync,
  output logic             frame_done,
  output logic [CNT_W-1:0] meas_w,
  output logic [CNT_W-1:0] meas_h,
  output logic             ok
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             dv_q, vs_q;
  logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, ref_w_q, ref_w_d;
  logic             ref_vld_q, ref_vld_d, bad_q, bad_d;
  logic             dv_fall;

  always_comb begin
    dv_fall    = dv_q & ~vid_datavalid;
    frame_done = vid_vsync & ~vs_q;
    pix_d      = pix_q;
    line_d     = line_q;
    ref_w_d    = ref_w_q;
    ref_vld_d  = ref_vld_q;
    bad_d      = bad_q;

    if (vid_datavalid) begin
      pix_d = CNT_W'(sat_inc(32'(pix_q), CNT_W));
      if (pix_q == CntMax) bad_d = 1'b1;
    end

    // A line ending in the vsync cycle still belongs to the closing frame.
    if (dv_fall) begin
      pix_d  = '0;
      line_d = CNT_W'(sat_inc(32'(line_q), CNT_W));
      if (line_q == CntMax) bad_d = 1'b1;
      if (!ref_vld_q) begin
        ref_w_d   = pix_q;
        ref_vld_d = 1'b1;
      end else if (pix_q != ref_w_q) begin
        bad_d = 1'b1;
      end
    end

    meas_w = ref_w_d;
    meas_h = line_d;
    ok     = ~bad_d & (ref_w_d != '0) & (line_d != '0);

    if (frame_done) begin
      line_d    = '0;
      ref_w_d   = '0;
      ref_vld_d = 1'b0;
      bad_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      ref_w_q   <= '0;
      ref_vld_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      dv_q      <= vid_datavalid;
      vs_q      <= vid_vsync;
      pix_q     <= pix_d;
      line_q    <= line_d;
      ref_w_q   <= ref_w_d;
      ref_vld_q <= ref_vld_d;
      bad_q     <= bad_d;
    end
  end

endmodule

// File: rtl/vid_resolution_detect.sv
// Locks onto a stable active resolution and publishes it with change/frame pulses.
module vid_resolution_detect
  import vid_res_pkg::*;
#(
  parameter int unsigned CNT_W         = CntW,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_datavalid,
  input  logic             vid_hsync,
  input  logic             vid_vsync,
  output logic [CNT_W-1:0] active_width,
  output logic [CNT_W-1:0] active_height,
  output logic             resolution_valid,
  output logic             resolution_change,
  output logic             frame_start
);

  localparam int unsigned StW = $clog2(STABLE_FRAMES + 1);

  logic             unused_hsync;
  logic             frame_done, ok;
  logic [CNT_W-1:0] meas_w, meas_h;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cand_w_q, cand_w_d, cand_h_q, cand_h_d;
  logic [CNT_W-1:0] act_w_q, act_w_d, act_h_q, act_h_d;
  logic [StW-1:0]   stable_q, stable_d;
  logic             valid_q, valid_d, change_q, change_d, fs_q, once_q, once_d;
  logic             try_lock;

  assign unused_hsync = vid_hsync;

  vid_line_counter #(
    .CNT_W(CNT_W)
  ) u_line_counter (
    .clk          (clk),
    .rst          (rst),
    .vid_datavalid(vid_datavalid),
    .vid_vsync    (vid_vsync),
    .frame_done   (frame_done),
    .meas_w       (meas_w),
    .meas_h       (meas_h),
    .ok           (ok)
  );

  always_comb begin
    state_d  = state_q;
    cand_w_d = cand_w_q;
    cand_h_d = cand_h_q;
    act_w_d  = act_w_q;
    act_h_d  = act_h_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    once_d   = once_q;
    try_lock = 1'b0;

    if (frame_done) begin
      unique case (state_q)
        StSearch: begin
          state_d  = StLocking;
          stable_d = '0;
          cand_w_d = '0;
          cand_h_d = '0;
        end
        StLocking: begin
          try_lock = 1'b1;
          if (ok && meas_w == cand_w_q && meas_h == cand_h_q) begin
            stable_d = stable_q + 1'b1;
          end else begin
            cand_w_d = meas_w;
            cand_h_d = meas_h;
            stable_d = StW'(ok);
          end
        end
        StLocked: begin
          if (!(ok && meas_w == act_w_q && meas_h == act_h_q)) begin
            state_d  = StLocking;
            valid_d  = 1'b0;
            cand_w_d = meas_w;
            cand_h_d = meas_h;
            stable_d = StW'(ok);
            try_lock = 1'b1;
          end
        end
        default: state_d = StSearch;
      endcase

      // Covers both normal locking and the single-frame relock out of StLocked.
      if (try_lock && stable_d == StW'(STABLE_FRAMES)) begin
        state_d  = StLocked;
        act_w_d  = cand_w_d;
        act_h_d  = cand_h_d;
        valid_d  = 1'b1;
        change_d = (cand_w_d != act_w_q) | (cand_h_d != act_h_q) | ~once_q;
        once_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StSearch;
      cand_w_q <= '0;
      cand_h_q <= '0;
      act_w_q  <= '0;
      act_h_q  <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      fs_q     <= 1'b0;
      once_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_w_q <= cand_w_d;
      cand_h_q <= cand_h_d;
      act_w_q  <= act_w_d;
      act_h_q  <= act_h_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      fs_q     <= frame_done;
      once_q   <= once_d;
    end
  end

  assign active_width      = act_w_q;
  assign active_height     = act_h_q;
  assign resolution_valid  = valid_q;
  assign resolution_change = change_q;
  assign frame_start       = fs_q;

endmodule

// File: tb/tb_vid_resolution_detect.sv
// Random and directed video streams checked against a frame-level lock model.
module tb_vid_resolution_detect;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv = 1'b0, hs = 1'b0, vs = 1'b0;

  logic [12:0] aw0, ah0, aw2, ah2;
  logic [3:0]  aw1, ah1;
  logic [NI-1:0] o_val, o_chg, o_fs;
  logic [31:0] o_aw[NI], o_ah[NI];

  vid_resolution_detect u_dut0 (
    .clk(clk), .rst(rst), .vid_datavalid(dv), .vid_hsync(hs), .vid_vsync(vs),
    .active_width(aw0), .active_height(ah0), .resolution_valid(o_val[0]),
    .resolution_change(o_chg[0]), .frame_start(o_fs[0])
  );
  vid_resolution_detect #(.CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .vid_datavalid(dv), .vid_hsync(hs), .vid_vsync(vs),
    .active_width(aw1), .active_height(ah1), .resolution_valid(o_val[1]),
    .resolution_change(o_chg[1]), .frame_start(o_fs[1])
  );
  vid_resolution_detect #(.STABLE_FRAMES(1)) u_dut2 (
    .clk(clk), .rst(rst), .vid_datavalid(dv), .vid_hsync(hs), .vid_vsync(vs),
    .active_width(aw2), .active_height(ah2), .resolution_valid(o_val[2]),
    .resolution_change(o_chg[2]), .frame_start(o_fs[2])
  );

  always_comb begin
    o_aw[0] = 32'(aw0); o_ah[0] = 32'(ah0);
    o_aw[1] = 32'(aw1); o_ah[1] = 32'(ah1);
    o_aw[2] = 32'(aw2); o_ah[2] = 32'(ah2);
  end

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 search, 1 locking, 2 locked.
  int unsigned m_max[NI] = '{8191, 15, 8191};
  int unsigned m_sf[NI]  = '{2, 2, 1};
  int unsigned m_state[NI], m_cw[NI], m_ch[NI], m_stab[NI], m_aw[NI], m_ah[NI];
  int unsigned m_valid[NI], m_chg[NI], m_once[NI];
  int unsigned m_fs;
  int lines[$];
  logic prev_vs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_state[i] = 0; m_cw[i] = 0; m_ch[i] = 0; m_stab[i] = 0;
      m_aw[i] = 0; m_ah[i] = 0; m_valid[i] = 0; m_chg[i] = 0; m_once[i] = 0;
    end
    m_fs = 0;
  endfunction

  function automatic void model_frame(input int i);
    int unsigned mw, mh;
    bit good;
    bit mis;
    mw = 0;
    good = (lines.size() > 0) && (lines.size() <= int'(m_max[i]));
    if (lines.size() > 0) begin
      mw = (lines[0] > int'(m_max[i])) ? m_max[i] : lines[0];
      if (lines[0] > int'(m_max[i])) good = 0;
      foreach (lines[k]) if (lines[k] != lines[0]) good = 0;
    end
    mh = (lines.size() > int'(m_max[i])) ? m_max[i] : lines.size();
    if (mw == 0) good = 0;
    m_chg[i] = 0;
    mis = 0;
    case (m_state[i])
      0: begin m_state[i] = 1; m_stab[i] = 0; m_cw[i] = 0; m_ch[i] = 0; end
      1: begin
        if (good && mw == m_cw[i] && mh == m_ch[i]) m_stab[i]++;
        else begin m_cw[i] = mw; m_ch[i] = mh; m_stab[i] = good; end
        mis = 1;
      end
      default: begin
        if (!(good && mw == m_aw[i] && mh == m_ah[i])) begin
          m_state[i] = 1; m_valid[i] = 0; m_cw[i] = mw; m_ch[i] = mh; m_stab[i] = good;
          mis = 1;
        end
      end
    endcase
    if (mis && m_stab[i] == m_sf[i]) begin
      m_state[i] = 2;
      m_chg[i] = (m_cw[i] != m_aw[i] || m_ch[i] != m_ah[i] || m_once[i] == 0);
      m_aw[i] = m_cw[i]; m_ah[i] = m_ch[i];
      m_valid[i] = 1; m_once[i] = 1;
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d valid", i), 32'(o_val[i]), m_valid[i]);
      check($sformatf("i%0d width", i), o_aw[i], m_aw[i]);
      check($sformatf("i%0d height", i), o_ah[i], m_ah[i]);
      check($sformatf("i%0d change", i), 32'(o_chg[i]), m_chg[i]);
      check($sformatf("i%0d frame_start", i), 32'(o_fs[i]), m_fs);
    end
  endtask

  task automatic tick(input logic d, input logic v);
    bit rise;
    @(negedge clk);
    dv = d; vs = v; hs = 1'($urandom_range(0, 1));
    rise = v && !prev_vs;
    prev_vs = v;
    @(posedge clk);
    #1;
    m_fs = rise;
    for (int i = 0; i < NI; i++) begin
      if (rise) model_frame(i);
      else m_chg[i] = 0;
    end
    check_outputs();
  endtask

  task automatic drive_frame(input int hblank, input int vs_hi, input int vs_lo, input bit tight);
    foreach (lines[li]) begin
      repeat (lines[li]) tick(1'b1, 1'b0);
      if (!(tight && li == lines.size() - 1)) repeat (hblank) tick(1'b0, 1'b0);
    end
    repeat (vs_hi) tick(1'b0, 1'b1);
    repeat (vs_lo) tick(1'b0, 1'b0);
  endtask

  task automatic set_lines(input int w, input int h);
    lines.delete();
    repeat (h) lines.push_back(w);
  endtask

  task automatic mid_frame_reset(input int partial);
    repeat (partial) tick(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    dv = 1'b0; vs = 1'b0; prev_vs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w, h, reps;
    model_reset();
    #1;
    check_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) tick(1'b0, 1'b0);

    // Lock onto 8x4.
    set_lines(8, 4);
    repeat (3) drive_frame(3, 2, 3, 1'b0);
    // Switch to 6x4.
    set_lines(6, 4);
    repeat (2) drive_frame(3, 2, 3, 1'b0);
    set_lines(8, 4);
    repeat (2) drive_frame(3, 2, 3, 1'b0);
    // One inconsistent frame, then recover to the same resolution.
    lines = '{8, 8, 7, 8};
    drive_frame(3, 2, 3, 1'b0);
    set_lines(8, 4);
    repeat (2) drive_frame(3, 2, 3, 1'b0);
    // Last line ends in the vsync cycle.
    repeat (3) drive_frame(2, 3, 2, 1'b1);
    // Reset while locked, then relock.
    mid_frame_reset(5);
    set_lines(8, 4);
    repeat (3) drive_frame(3, 2, 3, 1'b0);
    // Overlong lines saturate the narrow-counter instance.
    set_lines(20, 2);
    repeat (3) drive_frame(2, 1, 2, 1'b0);

    for (int g = 0; g < 70; g++) begin
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 14));
      h = int'($urandom_range(0, 6));
      reps = int'($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) mid_frame_reset(int'($urandom_range(1, 6)));
      for (int r = 0; r < reps; r++) begin
        set_lines(w, h);
        if (h > 1 && $urandom_range(0, 5) == 0) begin
          lines[$urandom_range(0, h - 1)] = (w > 1) ? w - 1 : w + 1;
        end
        drive_frame(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
